// File: rtl/instr_prefetch_unit.sv
// ---------------------------------------------------------------------------
// instr_prefetch_unit
//
// Instruction fetch stage. The program counter is sequenced separately from
// decode, and a prefetch queue sits between them. The unit issues one word
// fetch at a time over a req/ack handshake. It stores each returned word
// together with its PC and hands the entries to decode over valid/ready.
// A redirect flushes the queue and restarts fetch at the target. A response
// that was in flight when the redirect arrived is discarded.
//
// Parameters
//   XLEN        : PC / address width (32 or 64)
//   QUEUE_DEPTH : prefetch queue entries (power of two, >= 2)
//   RESET_PC    : first fetch address after reset (word aligned)
//
// Ports
//   clk_i            : clock, rising edge
//   rst_i            : synchronous active-high reset
//   redirect_valid_i : restart the fetch stream at redirect_pc_i
//   redirect_pc_i    : redirect target, bits [1:0] ignored
//   mem_req_o        : fetch request valid
//   mem_addr_o       : fetch address (word aligned)
//   mem_ack_i        : request accepted, mem_rdata_i valid this cycle
//   mem_rdata_i      : fetched instruction word
//   out_valid_o      : queue head valid
//   out_ready_i      : decode accepts the head entry
//   out_instr_o      : head instruction
//   out_pc_o         : head PC
//   stall_cycles_o   : (FETCH_PERF_EN only) saturating count of the cycles
//                      in which out_valid_o=1 and out_ready_i=0
//
// Build option
//   FETCH_PERF_EN : when defined, adds the stall_cycles_o port and its counter.
// ---------------------------------------------------------------------------
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no request outstanding
// WAIT  | request outstanding; the response will be enqueued
// DROP  | request outstanding; the response will be discarded (post-redirect)
// ---------------------------------------------------------------------------
module instr_prefetch_unit #(
   parameter int              XLEN        = 32,
   parameter int              QUEUE_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC    = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output logic            mem_req_o,
   output logic [XLEN-1:0] mem_addr_o,
   input  logic            mem_ack_i,
   input  logic [31:0]     mem_rdata_i,
`ifdef FETCH_PERF_EN
   output logic [31:0]     stall_cycles_o,
`endif
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [31:0]     out_instr_o,
   output logic [XLEN-1:0] out_pc_o
);

   localparam int PW = $clog2(QUEUE_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [31:0]     instr_q [QUEUE_DEPTH];
   logic [XLEN-1:0] pc_q    [QUEUE_DEPTH];

   logic            enq;
   logic            deq;
   logic            slot_free;
   logic [XLEN-1:0] redirect_tgt;

   // The low two bits of the target are forced to zero below.
   logic unused_redirect_lsbs;
   assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

   assign redirect_tgt = {redirect_pc_i[XLEN-1:2], 2'b00};

   always_comb begin
      enq          = 1'b0;
      deq          = 1'b0;
      slot_free    = 1'b0;
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      addr_d       = addr_q;
      count_d      = count_q;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;

      enq = (state_q == ST_WAIT) && mem_ack_i && !redirect_valid_i;
      deq = (count_q != '0) && out_ready_i;

      // A new request can be decided this cycle if nothing is outstanding,
      // or if the outstanding request completes this cycle.
      slot_free = (state_q == ST_IDLE) || mem_ack_i;

      if (redirect_valid_i) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         count_d  = count_q + CW'(enq) - CW'(deq);
         rd_ptr_d = rd_ptr_q + PW'(deq);
         wr_ptr_d = wr_ptr_q + PW'(enq);
      end

      if (redirect_valid_i) begin
         fetch_pc_d = redirect_tgt;
      end else if ((state_q == ST_WAIT) && mem_ack_i) begin
         fetch_pc_d = addr_q + XLEN'(4);
      end

      // A request is issued only if the queue will still have a free slot
      // after this cycle's enqueue/dequeue, so an ack never has to stall.
      // When a DROP request completes, the next fetch is issued directly
      // from DROP (the same rule as in WAIT), which keeps redirect-to-request
      // latency at ack cycle + 1.
      if (slot_free) begin
         if (count_d < CW'(QUEUE_DEPTH)) begin
            state_d = ST_WAIT;
            addr_d  = fetch_pc_d;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (redirect_valid_i && (state_q == ST_WAIT)) begin
         state_d = ST_DROP;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         for (int i = 0; i < QUEUE_DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         if (enq) begin
            instr_q[wr_ptr_q] <= mem_rdata_i;
            pc_q[wr_ptr_q]    <= addr_q;
         end
      end
   end

   assign mem_req_o   = (state_q != ST_IDLE);
   assign mem_addr_o  = addr_q;
   assign out_valid_o = (count_q != '0);
   assign out_instr_o = instr_q[rd_ptr_q];
   assign out_pc_o    = pc_q[rd_ptr_q];

`ifdef FETCH_PERF_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_q <= '0;
      end else if (out_valid_o && !out_ready_i && (stall_q != '1)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles_o = stall_q;
`endif

endmodule
